// File: rtl/branch_predictor_pkg.sv
// ----------------------------------------------------------------------------
// bp_pkg: shared types and helpers for the fetch-stage branch predictor.
//   ctr_t      : 2-bit saturating direction counter encoding
//   CTR_RESET  : counter value after reset (weakly not-taken)
//   CTR_ALLOC  : counter value for a freshly allocated entry (weakly taken)
//   ctr_next() : saturating increment/decrement of a counter
// ----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WEAK_NT;
    localparam ctr_t CTR_ALLOC = WEAK_T;

    // Move one step toward the resolved direction; hold at either end.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != STRONG_T) nxt = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != STRONG_NT) nxt = ctr_t'(ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_predictor_if: fetch lookup and execute write-back bundle.
//   Fetch  : pc_f -> pred_taken, pred_target (combinational, same cycle)
//   Update : upd_valid qualifies upd_pc/upd_taken/upd_target/upd_pred_taken.
//            There is no ready: the predictor always accepts an update, and
//            a cycle with upd_valid=1 is exactly one resolved branch. With
//            upd_valid=0 the upd_* fields are ignored.
//   master : the core (drives pc_f and upd_*)
//   slave  : the predictor
// ----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_f;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;
    logic             upd_valid;
    logic [WIDTH-1:0] upd_pc;
    logic             upd_taken;
    logic [WIDTH-1:0] upd_target;
    logic             upd_pred_taken;

    modport master (
        output pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_taken, pred_target
    );

    modport slave (
        input  pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_taken, pred_target
    );
endinterface

// File: rtl/branch_predictor_stats.sv
// ----------------------------------------------------------------------------
// bp_stats: resolved-branch and misprediction counters (built only with
// BP_STATS_EN defined).
//   clk, reset_n        : clock, async active-low reset
//   upd_valid           : one resolved branch this cycle
//   upd_taken           : resolved direction
//   upd_pred_taken      : direction that was predicted at fetch
//   stat_branches       : count of resolved branches (wraps)
//   stat_mispredicts    : count of direction mispredictions (wraps)
// ----------------------------------------------------------------------------
module bp_stats (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        upd_valid,
    input  logic        upd_taken,
    input  logic        upd_pred_taken,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (upd_valid) begin
            stat_branches <= stat_branches + 32'd1;
            if (upd_taken != upd_pred_taken)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor: direct-mapped fetch-stage predictor, one 2-bit counter,
// tag and target per entry.
//   clk, reset_n     : clock, async active-low reset
//   bp (slave)       : fetch lookup + execute write-back (branch_predictor_if)
//   stat_branches    : resolved-branch count    (only with BP_STATS_EN)
//   stat_mispredicts : misprediction count      (only with BP_STATS_EN)
// Optional feature macro: BP_STATS_EN adds the statistics counters.
// ----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic clk,
    input  logic reset_n,
    branch_predictor_if.slave bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int TAG_BITS = WIDTH - INDEX_BITS - 2;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic                valid_q  [ENTRIES];
    ctr_t                ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [WIDTH-1:0]    target_q [ENTRIES];

    // Fetch-side lookup: reads the current table state only, so an update
    // to the same index in this cycle is not seen until the next one.
    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;

    assign f_idx = bp.pc_f[INDEX_BITS+1:2];
    assign f_tag = bp.pc_f[WIDTH-1:INDEX_BITS+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign bp.pred_taken  = f_hit && ctr_q[f_idx][1];
    assign bp.pred_target = bp.pred_taken ? target_q[f_idx] : bp.pc_f + WIDTH'(4);

    // Execute-side write-back.
    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;

    assign u_idx = bp.upd_pc[INDEX_BITS+1:2];
    assign u_tag = bp.upd_pc[WIDTH-1:INDEX_BITS+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Valid bits and counters carry all the reset state. A hit trains the
    // counter; a taken miss (re)allocates, evicting any other tag; a
    // not-taken miss leaves the table alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (bp.upd_valid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_next(ctr_q[u_idx], bp.upd_taken);
            end else if (bp.upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= CTR_ALLOC;
            end
        end
    end

    // Tag/target need no reset: they are only observed through a set valid
    // bit. Every taken update writes them; on a hit the tag is unchanged and
    // the target is refreshed, on a miss this is the allocation.
    always_ff @(posedge clk) begin
        if (bp.upd_valid && bp.upd_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bp.upd_target;
        end
    end

`ifdef BP_STATS_EN
    bp_stats u_stats (
        .clk              (clk),
        .reset_n          (reset_n),
        .upd_valid        (bp.upd_valid),
        .upd_taken        (bp.upd_taken),
        .upd_pred_taken   (bp.upd_pred_taken),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );
`endif

    // Byte-offset bits and (without stats) the piped prediction are unused.
    logic unused_ok;
    assign unused_ok = ^{bp.pc_f[1:0], bp.upd_pc[1:0], bp.upd_pred_taken};

endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor: directed self-checking bench for branch_predictor.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q[$];

    branch_predictor_if #(.WIDTH(32)) bp_if ();

`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.WIDTH(32), .INDEX_BITS(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bp      (bp_if)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_pc         = 32'h0;
        bp_if.upd_taken      = 1'b0;
        bp_if.upd_target     = 32'h0;
        bp_if.upd_pred_taken = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic pred);
        @(negedge clk);
        bp_if.upd_pc         = pc;
        bp_if.upd_taken      = taken;
        bp_if.upd_target     = tgt;
        bp_if.upd_pred_taken = pred;
        bp_if.upd_valid      = 1'b1;
        @(posedge clk);
        #1 bp_if.upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic exp_t,
                          input logic [31:0] exp_tgt, input string tag);
        @(negedge clk);
        bp_if.pc_f = pc;
        #1;
        check({tag, "_taken"}, 32'(bp_if.pred_taken), 32'(exp_t));
        check({tag, "_target"}, bp_if.pred_target, exp_tgt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b1;
        bp_if.pc_f = 32'h100;
        idle_inputs();

        // Reset: observe during and after.
        #1 reset_n = 1'b0;
        #2;
        check("rst_during_taken", 32'(bp_if.pred_taken), 32'h0);
        check("rst_during_target", bp_if.pred_target, 32'h104);
        @(negedge clk);
        reset_n = 1'b1;
        lookup(32'h100, 1'b0, 32'h104, "rst_after");

        // Every index misses after reset.
        for (int i = 0; i < 64; i++) exp_q.push_back(32'(i * 4 + 4));
        for (int i = 0; i < 64; i++) lookup(32'(i * 4), 1'b0, exp_q.pop_front(), "sweep");

        // Allocation -> weakly taken.
        update(32'h200, 1'b1, 32'h180, 1'b0);
        lookup(32'h200, 1'b1, 32'h180, "alloc");

        // Climb to strongly taken, then hysteresis on the way down.
        for (int i = 0; i < 3; i++) update(32'h200, 1'b1, 32'h180, 1'b1);
        lookup(32'h200, 1'b1, 32'h180, "strong_t");
        update(32'h200, 1'b0, 32'h0, 1'b1);
        lookup(32'h200, 1'b1, 32'h180, "hyst_1nt");
        update(32'h200, 1'b0, 32'h0, 1'b1);
        lookup(32'h200, 1'b0, 32'h204, "hyst_2nt");
        for (int i = 0; i < 5; i++) update(32'h200, 1'b0, 32'h0, 1'b0);
        lookup(32'h200, 1'b0, 32'h204, "strong_nt");
        // From STRONG_NT one taken is not enough; two are. Target refreshes.
        update(32'h200, 1'b1, 32'h1A0, 1'b0);
        lookup(32'h200, 1'b0, 32'h204, "sat_floor");
        update(32'h200, 1'b1, 32'h1A0, 1'b0);
        lookup(32'h200, 1'b1, 32'h1A0, "retarget");

        // Aliasing: 0x1200 shares index 0 with 0x200, different tag.
        update(32'h1200, 1'b1, 32'h40, 1'b0);
        lookup(32'h200, 1'b0, 32'h204, "alias_old");
        lookup(32'h1200, 1'b1, 32'h40, "alias_new");
        // Not-taken miss leaves the occupant alone.
        update(32'h600, 1'b0, 32'h0, 1'b0);
        lookup(32'h1200, 1'b1, 32'h40, "nt_miss");

        // upd_valid=0 with live-looking fields changes nothing.
        @(negedge clk);
        bp_if.upd_pc    = 32'h400;
        bp_if.upd_taken = 1'b1;
        bp_if.upd_target = 32'h999;
        @(negedge clk);
        idle_inputs();
        lookup(32'h400, 1'b0, 32'h404, "no_valid");

        // Same-cycle lookup and update: pre-update result, commit at edge.
        @(negedge clk);
        bp_if.pc_f           = 32'h300;
        bp_if.upd_pc         = 32'h300;
        bp_if.upd_taken      = 1'b1;
        bp_if.upd_target     = 32'h3C0;
        bp_if.upd_pred_taken = 1'b0;
        bp_if.upd_valid      = 1'b1;
        #1;
        check("coll_same_taken", 32'(bp_if.pred_taken), 32'h0);
        check("coll_same_target", bp_if.pred_target, 32'h304);
        @(posedge clk);
        #1 bp_if.upd_valid = 1'b0;
        check("coll_next_taken", 32'(bp_if.pred_taken), 32'h1);
        check("coll_next_target", bp_if.pred_target, 32'h3C0);

        // pc_f + 4 wraps at the top of the address space.
        lookup(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap");

        // Reset arriving while an update is pending discards it.
        @(negedge clk);
        bp_if.upd_pc     = 32'h500;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_target = 32'h77C;
        bp_if.upd_valid  = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        lookup(32'h500, 1'b0, 32'h504, "rst_mid_upd");
        lookup(32'h300, 1'b0, 32'h304, "rst_clears");

`ifdef BP_STATS_EN
        begin
            logic [9:0] mis;
            mis = 10'b00_1001_0010;
            apply_reset();
            #1;
            check("stat_rst_br", stat_branches, 32'd0);
            check("stat_rst_mis", stat_mispredicts, 32'd0);
            for (int i = 0; i < 10; i++)
                update(32'(32'h700 + i * 4), 1'(i % 2), 32'h80, 1'(i % 2) ^ mis[i]);
            @(negedge clk);
            check("stat_branches", stat_branches, 32'd10);
            check("stat_mispredicts", stat_mispredicts, 32'd3);
            reset_n = 1'b0;
            #1;
            check("stat_clr_br", stat_branches, 32'd0);
            check("stat_clr_mis", stat_mispredicts, 32'd0);
            @(negedge clk);
            reset_n = 1'b1;
        end
`endif

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the pipelined RV32 core.
- Direct-mapped table: one 2-bit saturating counter, tag and target per entry.
- Fetch side gets a combinational prediction for the current PC.
- Execute side writes back the resolved outcome (the branch controller's pc_sel) and the computed target. The table trains on that write-back.

Parameters:
WIDTH, 32, PC/target width in bits
INDEX_BITS, 6, log2 of table entries (64 entries)
TAG_BITS, WIDTH-INDEX_BITS-2, derived localparam; stored tag width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
pc_f  input  WIDTH  fetch-stage PC (word aligned)
pred_taken  output  1  prediction for pc_f: 1 = redirect fetch
pred_target  output  WIDTH  next-fetch PC: predicted target, or pc_f+4
upd_valid  input  1  resolved conditional branch present in execute this cycle
upd_pc  input  WIDTH  PC of the resolved branch
upd_taken  input  1  resolved direction (branch controller pc_sel)
upd_target  input  WIDTH  computed branch target
upd_pred_taken  input  1  prediction originally made for this branch, piped from fetch
stat_branches  output  32  resolved-branch count (BP_STATS_EN only)
stat_mispredicts  output  32  misprediction count (BP_STATS_EN only)

Behaviour:
- Indexing:
  - idx = pc[INDEX_BITS+1:2]
  - tag = pc[WIDTH-1:INDEX_BITS+2]
  - pc[1:0] ignored.
- Lookup is combinational, with zero-cycle latency:
  - hit = valid[idx(pc_f)] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = stored target when pred_taken, else pc_f+4 (modulo 2^WIDTH; wraps at all-ones).
- Update is registered on the clk rising edge when upd_valid=1. It is visible to lookup from the next cycle.
- Update on a hit:
  - Counter saturating: +1 if upd_taken, -1 otherwise.
  - Saturates at 2'b11 and 2'b00; no wrap.
  - If upd_taken, target is overwritten with upd_target.
- Update on a miss:
  - If upd_taken: allocate the entry (valid=1, tag=tag(upd_pc), target=upd_target, ctr=2'b10 weakly taken). Any different-tag occupant is replaced.
  - If not taken: no change.
- upd_valid=0: table unchanged. upd_* fields are don't-care.
- Simultaneous lookup and update of the same index in one cycle:
  - Lookup returns the pre-update contents; no bypass.
  - The update commits at the edge.
- Reset (async assert, sync deassert handled at the top level):
  - All valid bits cleared; all counters set to 2'b01 (weakly not-taken).
  - Therefore pred_taken=0 and pred_target=pc_f+4 during and after reset until the first allocation.
- Reset mid-update: the in-flight update is discarded.
- Storage:
  - Only valid bits and counters need reset.
  - Tag/target arrays may be non-reset flops, since they are gated by valid.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - stat_branches increments on every upd_valid=1 cycle.
  - stat_mispredicts increments when upd_valid=1 and upd_taken != upd_pred_taken.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined:
  - Both stat ports and their counters are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package bp_pkg:
  - Typedef ctr_t enum {STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11}.
  - Constant CTR_RESET=WEAK_NT; constant CTR_ALLOC=WEAK_T.
  - Function ctr_next(ctr_t, logic taken) implementing saturation.
- Sub-module bp_stats: the two counters, instantiated only under BP_STATS_EN. Table logic stays in branch_predictor.

Test Plan:
- Reset: reset_n=0 then release, pc_f=0x100 -> pred_taken=0, pred_target=0x104. Sweep all 64 indices -> pred_taken=0 on each.
- Allocation: update upd_pc=0x200, upd_taken=1, upd_target=0x180. Next cycle pc_f=0x200 -> pred_taken=1, pred_target=0x180 (ctr=WEAK_T).
- Saturation/hysteresis: after allocation, 3 more taken updates on 0x200 -> ctr=STRONG_T.
  - Then 1 not-taken -> pred_taken still 1.
  - Then 2nd not-taken -> ctr=WEAK_NT, pred_taken=0.
  - Then 5 not-taken -> ctr stays STRONG_NT.
- Aliasing: allocate 0x200 (taken→0x180), then update 0x1200 (same idx, different tag) taken→0x40. Expect:
  - pc_f=0x200 -> pred_taken=0, pred_target=0x204
  - pc_f=0x1200 -> pred_target=0x40
- Same-cycle collision: pc_f=0x300 with upd_valid=1, upd_pc=0x300, taken→0x3C0 on an empty entry -> that cycle pred_taken=0. Next cycle pred_taken=1, pred_target=0x3C0.
- Stats (BP_STATS_EN): 10 updates, 3 with upd_taken != upd_pred_taken -> stat_branches=10, stat_mispredicts=3. Assert reset_n mid-sequence -> both 0.
